// File: rtl/coproc_pkg.sv
// Shared constants and types for the scalar-multiply coprocessor datapath.
// The loader and the ALU stage both take the operand width FLAT_W from here.
package coproc_pkg;

  localparam int N      = 5;
  localparam int DW     = 8;
  localparam int ELEMS  = N * N;
  localparam int FLAT_W = ELEMS * DW;
  localparam int IDX_W  = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = 5'd24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_S = 2'd2,
    HOLD   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/matrix_scalar_loader.sv
// Collects 25 matrix bytes plus one scalar byte from a valid/ready stream
// and holds the assembled operands until the ALU stage acknowledges them.
module matrix_scalar_loader
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic [FLAT_W-1:0] A_flat,
  output logic [DW-1:0]     scalar,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [IDX_W-1:0]  elem_idx,
  output logic              busy
);

  loader_state_e     state_r;
  loader_state_e     next_state_s;
  logic              in_ready_s;
  logic              transfer_s;
  logic [FLAT_W-1:0] a_flat_r;
  logic [DW-1:0]     scalar_r;
  logic              out_valid_r;
  logic [IDX_W-1:0]  elem_idx_r;
  logic              busy_r;

  assign in_ready_s = (state_r == LOAD_A) || (state_r == LOAD_S);
  assign transfer_s = in_valid && in_ready_s;

  // Next-state decode; abort overrides every other input.
  always_comb begin
    next_state_s = state_r;
    if (abort) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) next_state_s = LOAD_A;
          else       next_state_s = IDLE;
        end
        LOAD_A: begin
          if (transfer_s && (elem_idx_r == LAST_IDX)) next_state_s = LOAD_S;
          else                                        next_state_s = LOAD_A;
        end
        LOAD_S: begin
          if (transfer_s) next_state_s = HOLD;
          else            next_state_s = LOAD_S;
        end
        HOLD: begin
          if (out_ack) next_state_s = IDLE;
          else         next_state_s = HOLD;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register and the busy flag derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
    end
  end

  // Operand capture, element counter and output-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_flat_r    <= '0;
      scalar_r    <= 8'd0;
      elem_idx_r  <= 5'd0;
      out_valid_r <= 1'b0;
    end else if (abort) begin
      a_flat_r    <= '0;
      scalar_r    <= 8'd0;
      elem_idx_r  <= 5'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Scalar is kept from the previous load; only the matrix is cleared.
          if (start) begin
            a_flat_r   <= '0;
            elem_idx_r <= 5'd0;
          end
        end
        LOAD_A: begin
          if (transfer_s) begin
            for (int i = 0; i < ELEMS; i++) begin
              if (elem_idx_r == IDX_W'(i)) a_flat_r[i*DW +: DW] <= in_data;
            end
            elem_idx_r <= elem_idx_r + 5'd1;
          end
        end
        LOAD_S: begin
          if (transfer_s) begin
            scalar_r    <= in_data;
            out_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ack) begin
            out_valid_r <= 1'b0;
            elem_idx_r  <= 5'd0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          elem_idx_r  <= 5'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign A_flat    = a_flat_r;
  assign scalar    = scalar_r;
  assign out_valid = out_valid_r;
  assign elem_idx  = elem_idx_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_matrix_scalar_loader.sv
// Directed bench for matrix_scalar_loader: a transaction-level model is
// compared against the DUT every cycle, plus hand-computed spot values.
module tb_matrix_scalar_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_ready;
  logic [199:0] A_flat;
  logic [7:0]   scalar;
  logic         out_valid;
  logic         out_ack = 1'b0;
  logic [4:0]   elem_idx;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  matrix_scalar_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .A_flat(A_flat), .scalar(scalar), .out_valid(out_valid),
    .out_ack(out_ack), .elem_idx(elem_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: phase 0 idle, 1 collecting matrix, 2 awaiting scalar, 3 holding.
  int         m_phase = 0;
  int         m_cnt = 0;
  logic [7:0] m_a [25];
  logic [7:0] m_s = 8'd0;
  bit         m_ov = 1'b0;

  task automatic model_clear();
    for (int i = 0; i < 25; i++) m_a[i] = 8'd0;
    m_s = 8'd0;
  endtask

  initial model_clear();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      m_phase = 0; m_cnt = 0; m_ov = 1'b0;
    end else begin
      bit xfer;
      xfer = in_valid && (m_phase == 1 || m_phase == 2);
      if (abort) begin
        model_clear();
        m_phase = 0; m_cnt = 0; m_ov = 1'b0;
      end else if (m_phase == 0) begin
        if (start) begin
          for (int i = 0; i < 25; i++) m_a[i] = 8'd0;
          m_cnt = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (xfer) begin
          m_a[m_cnt] = in_data;
          m_cnt++;
          if (m_cnt == 25) m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (xfer) begin
          m_s = in_data; m_ov = 1'b1; m_phase = 3;
        end
      end else if (out_ack) begin
        m_ov = 1'b0; m_cnt = 0; m_phase = 0;
      end
    end
  end

  function automatic logic [199:0] model_flat();
    logic [199:0] f;
    f = '0;
    for (int i = 0; i < 25; i++) f[i*8 +: 8] = m_a[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("A_flat", A_flat, model_flat());
    chk("scalar", {192'd0, scalar}, {192'd0, m_s});
    chk("out_valid", {199'd0, out_valid}, {199'd0, m_ov});
    chk("elem_idx", {195'd0, elem_idx}, 200'(m_cnt));
    chk("busy", {199'd0, busy}, {199'd0, (m_phase != 0)});
    chk("in_ready", {199'd0, in_ready}, {199'd0, (m_phase == 1 || m_phase == 2)});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one byte until it is accepted, optionally stalling in_valid.
  task automatic send(input logic [7:0] b, input int stall_pct);
    bit done = 1'b0;
    bit xf;
    int guard = 0;
    in_data = b;
    while (!done && guard < 200) begin
      in_valid = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      xf = in_valid && in_ready;
      tick();
      done = xf;
      guard++;
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  logic [199:0] saved_a;
  logic [7:0]   saved_s;
  int           start_cyc;
  logic [4:0]   idx_before;

  initial begin
    #1;
    chk("reset_A_flat", A_flat, 200'd0);
    chk("reset_ovalid_busy_ready", {197'd0, out_valid, busy, in_ready}, 200'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_ignore_busy", {199'd0, busy}, 200'd0);
    chk("idle_ignore_A", A_flat, 200'd0);

    // Back-to-back load, minimum latency
    pulse_start();
    start_cyc = cyc;
    for (int i = 1; i <= 25; i++) send(8'(i), 0);
    send(8'hFE, 0);
    chk("latency_out_valid", {199'd0, out_valid}, 200'd1);
    chk("latency_cycles", 200'(cyc - start_cyc + 1), 200'd27);
    chk("lit_A_low", {192'd0, A_flat[7:0]}, 200'h01);
    chk("lit_A_high", {192'd0, A_flat[199:192]}, 200'h19);
    chk("lit_scalar", {192'd0, scalar}, 200'hFE);
    chk("hold_in_ready", {199'd0, in_ready}, 200'd0);

    // Hold for 10 cycles, then acknowledge
    saved_a = A_flat; saved_s = scalar;
    repeat (10) tick();
    chk("hold_stable_A", A_flat, saved_a);
    chk("hold_valid", {199'd0, out_valid}, 200'd1);
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    chk("ack_valid_low", {199'd0, out_valid}, 200'd0);
    chk("ack_idle", {199'd0, busy}, 200'd0);
    chk("ack_retain_A", A_flat, saved_a);
    chk("ack_retain_s", {192'd0, scalar}, {192'd0, saved_s});
    tick();

    // Stalled stream with a stray start during LOAD_A
    pulse_start();
    for (int i = 1; i <= 25; i++) begin
      if (i == 6) start = 1'b1;
      send(8'(i), 50);
      start = 1'b0;
    end
    chk("stall_elem_idx", {195'd0, elem_idx}, 200'd25);
    send(8'hFE, 50);
    chk("stall_same_A", A_flat, saved_a);
    chk("stall_same_s", {192'd0, scalar}, 200'hFE);

    // start together with out_ack in HOLD is ignored
    start = 1'b1; out_ack = 1'b1; tick();
    start = 1'b0; out_ack = 1'b0;
    chk("ack_start_idle", {198'd0, busy, in_ready}, 200'd0);
    tick();

    // Abort after 12 elements, with a transfer in the abort cycle
    pulse_start();
    for (int i = 0; i < 12; i++) send(8'(8'h40 + i), 0);
    idx_before = elem_idx;
    chk("pre_abort_idx", {195'd0, idx_before}, 200'd12);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h77; tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_A", A_flat, 200'd0);
    chk("abort_idx", {195'd0, elem_idx}, 200'd0);
    chk("abort_idle", {199'd0, busy}, 200'd0);
    chk("abort_scalar", {192'd0, scalar}, 200'd0);

    // Full load after abort
    pulse_start();
    for (int i = 0; i < 25; i++) send(8'(8'h80 + i), 20);
    send(8'h7F, 20);
    chk("post_abort_A0", {192'd0, A_flat[7:0]}, 200'h80);
    chk("post_abort_A24", {192'd0, A_flat[199:192]}, 200'h98);
    chk("post_abort_s", {192'd0, scalar}, 200'h7F);
    out_ack = 1'b1; tick(); out_ack = 1'b0;

    // Asynchronous reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 7; i++) send(8'(8'hA0 + i), 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_A", A_flat, 200'd0);
    chk("async_rst_ctl", {192'd0, elem_idx, out_valid, busy, in_ready}, 200'd0);
    chk("async_rst_scalar", {192'd0, scalar}, 200'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
